riscv_int_controller_mc: RTL and testbench
==========================================

// Module: riscv_int_controller_mc
// PURPOSE
//  Multi-line interrupt controller between the external interrupt lines and the core controller.
//  Arbitrates NUM_IRQ lines by fixed priority (highest index wins), gates them with the CSR mask and
//  privilege-dependent global enable, and presents a single request/id/secure triple to the controller
//  with the existing ack/kill handshake. Adds an ack pulse back to the interrupt source.
// PARAMETERS
//  NUM_IRQ      32  number of interrupt lines, 2..64
//  ID_W         6   width of id outputs; must satisfy 2**ID_W >= NUM_IRQ
//  PULP_SECURE  0   1: privilege-aware enable (U/M); 0: enable = m_IE_i only
// PORTS
//  clk                 in   1        clock
//  rst_n               in   1        async reset, active low
//  irq_i               in   NUM_IRQ  interrupt lines (level; edge when RISCV_INT_EDGE_EN)
//  irq_mask_i          in   NUM_IRQ  per-line enable (mie)
//  irq_sec_i           in   NUM_IRQ  per-line secure attribute
//  m_IE_i              in   1        global enable, M mode
//  u_IE_i              in   1        global enable, U mode
//  current_priv_lvl_i  in   2        PrivLvl_t current privilege
//  irq_req_ctrl_o      out  1        request to controller
//  irq_sec_ctrl_o      out  1        secure bit of presented request
//  irq_id_ctrl_o       out  ID_W     id of presented request
//  ctrl_ack_i          in   1        controller accepted request
//  ctrl_kill_i         in   1        controller withdrew request (e.g. debug/flush)
//  irq_ack_o           out  1        1-cycle pulse: interrupt taken
//  irq_ack_id_o        out  ID_W     id of taken interrupt, valid with irq_ack_o
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; id/sec registers 0; edge pending/history flops 0.
//  - act[i] = src[i] & irq_mask_i[i]; src = irq_i (level) or pend_q (edge). sel = highest i with act[i].
//  - enable: PULP_SECURE=1: ((u_IE_i | irq_sec_i[sel]) & priv==U) | (m_IE_i & priv==M); else m_IE_i.
//  - FSM IDLE: if enable & |act -> PENDING; capture id_q=sel, sec_q=irq_sec_i[sel].
//    Latency: line valid at edge n -> irq_req_ctrl_o=1 after edge n+1 (one registered stage).
//  - FSM PENDING: irq_req_ctrl_o=1 (decoded from state only).
//    ctrl_ack_i -> DONE (ack has priority when ack & kill same cycle).
//    else ctrl_kill_i -> IDLE, no ack pulse, sec_q/id_q held.
//    else if enable & act has sel > id_q -> id_q/sec_q updated to sel (pre-acceptance preemption);
//    stay PENDING. Line deassertion alone never cancels request; only kill does.
//  - FSM DONE: irq_ack_o=1, irq_ack_id_o=id_q for exactly this cycle; sec_q<=0; -> IDLE.
//    New request earliest in the cycle after DONE (no back-to-back PENDING).
//  - Id zero-extended to ID_W; lines >= NUM_IRQ do not exist.
//  - Global enable dropping while PENDING does not cancel the request (controller kills).
//  - rst_n asserted in any state: immediate return to reset values, no ack pulse.
// CONFIGURATION
//  RISCV_INT_EDGE_EN defined: per-line pend_q set on rising edge of irq_i (history flop vs input);
//    cleared in DONE for id_q; set and clear same line same cycle -> set wins; kill does not clear.
//    Masked lines still latch pend_q.
//  RISCV_INT_EDGE_EN undefined: level-sensitive, src=irq_i; no pend_q/history flops; source must
//    hold line until irq_ack_o or own deassertion.
// TESTING
//  1 irq_i=1<<5, mask all 1, m_IE=1, M mode -> req=1 next cycle, id=5; ack -> ack pulse, ack_id=5, IDLE.
//  2 irq_i bits 3 and 17 same cycle -> id=17; bit 17 clears with bit 3 held -> next request id=3.
//  3 PENDING id=4, bit 9 rises, no ack -> id=9 next cycle; ack same cycle as rise -> id stays 4.
//  4 ack & kill same cycle in PENDING -> DONE, ack pulse; kill alone -> IDLE, no pulse, re-request.
//  5 PULP_SECURE=1, U mode, u_IE=0, line 2 sec=1 -> req, sec_ctrl=1; sec=0 -> no req.
//  6 EDGE_EN: 1-cycle pulse on bit 7 while busy -> served after; rst_n mid-PENDING -> outputs 0.

Source files
------------

// File: rtl/riscv_int_controller_mc_if.sv
// ---------------------------------------------------------------------------
// riscv_int_controller_mc_if
//
// Purpose:
//   Bundles the interrupt-line inputs, the CSR gating inputs and the
//   request/ack/kill handshake between the multi-line interrupt controller
//   and the core controller.
//
// Parameters:
//   NUM_IRQ  number of interrupt lines
//   ID_W     width of the id fields
//
// Signals (direction seen from the interrupt controller):
//   irq_i               in   NUM_IRQ  interrupt lines
//   irq_mask_i          in   NUM_IRQ  per-line enable (mie)
//   irq_sec_i           in   NUM_IRQ  per-line secure attribute
//   m_IE_i              in   1        global enable, M mode
//   u_IE_i              in   1        global enable, U mode
//   current_priv_lvl_i  in   2        current privilege level
//   irq_req_ctrl_o      out  1        request to core controller
//   irq_sec_ctrl_o      out  1        secure bit of presented request
//   irq_id_ctrl_o       out  ID_W     id of presented request
//   ctrl_ack_i          in   1        controller accepted request
//   ctrl_kill_i         in   1        controller withdrew request
//   irq_ack_o           out  1        one-cycle pulse: interrupt taken
//   irq_ack_id_o        out  ID_W     id of taken interrupt
//
// Modports:
//   master  the interrupt controller
//   slave   the environment (interrupt sources, CSRs, core controller)
// ---------------------------------------------------------------------------
interface riscv_int_controller_mc_if #(
    parameter int NUM_IRQ = 32,
    parameter int ID_W    = 6
);
    logic [NUM_IRQ-1:0] irq_i;
    logic [NUM_IRQ-1:0] irq_mask_i;
    logic [NUM_IRQ-1:0] irq_sec_i;
    logic               m_IE_i;
    logic               u_IE_i;
    logic [1:0]         current_priv_lvl_i;
    logic               irq_req_ctrl_o;
    logic               irq_sec_ctrl_o;
    logic [ID_W-1:0]    irq_id_ctrl_o;
    logic               ctrl_ack_i;
    logic               ctrl_kill_i;
    logic               irq_ack_o;
    logic [ID_W-1:0]    irq_ack_id_o;

    modport master (
        input  irq_i,
        input  irq_mask_i,
        input  irq_sec_i,
        input  m_IE_i,
        input  u_IE_i,
        input  current_priv_lvl_i,
        output irq_req_ctrl_o,
        output irq_sec_ctrl_o,
        output irq_id_ctrl_o,
        input  ctrl_ack_i,
        input  ctrl_kill_i,
        output irq_ack_o,
        output irq_ack_id_o
    );

    modport slave (
        output irq_i,
        output irq_mask_i,
        output irq_sec_i,
        output m_IE_i,
        output u_IE_i,
        output current_priv_lvl_i,
        input  irq_req_ctrl_o,
        input  irq_sec_ctrl_o,
        input  irq_id_ctrl_o,
        output ctrl_ack_i,
        output ctrl_kill_i,
        input  irq_ack_o,
        input  irq_ack_id_o
    );
endinterface

// File: rtl/riscv_int_controller_mc.sv
// ---------------------------------------------------------------------------
// riscv_int_controller_mc
//
// Purpose:
//   Multi-line interrupt controller sitting between the external interrupt
//   lines and the core controller. Lines are gated by the per-line mask,
//   arbitrated by fixed priority (highest index wins) and qualified by a
//   privilege-dependent global enable. The winner is presented to the core
//   controller as a request/id/secure triple with an ack/kill handshake; on
//   acceptance a one-cycle ack pulse with the taken id is returned towards
//   the interrupt source.
//
// Parameters:
//   NUM_IRQ      number of interrupt lines (2..64); must match bus.NUM_IRQ
//   ID_W         id width, 2**ID_W >= NUM_IRQ; must match bus.ID_W
//   PULP_SECURE  1: privilege-aware global enable (U/M), 0: m_IE_i only
//
// Ports:
//   clk    clock
//   rst_n  asynchronous reset, active low
//   bus    riscv_int_controller_mc_if.master (lines, CSR gating, handshake)
//
// Configuration macro:
//   RISCV_INT_EDGE_EN  defined: lines are rising-edge sensitive, each edge
//                      latched in a per-line pending flop until taken.
//                      undefined: lines are level sensitive.
// ---------------------------------------------------------------------------
module riscv_int_controller_mc #(
    parameter int NUM_IRQ     = 32,
    parameter int ID_W        = 6,
    parameter bit PULP_SECURE = 1'b0
) (
    input logic                       clk,
    input logic                       rst_n,
    riscv_int_controller_mc_if.master bus
);

    localparam logic [1:0] PRIV_LVL_U = 2'b00;
    localparam logic [1:0] PRIV_LVL_M = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DONE    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               sec_q, sec_d;
    logic               req_q, req_d;
    logic               ack_q, ack_d;
    logic [ID_W-1:0]    ack_id_q, ack_id_d;

    logic [NUM_IRQ-1:0] src;
    logic [NUM_IRQ-1:0] act;
    logic [ID_W-1:0]    sel;
    logic               sel_sec;
    logic               any_act;
    logic               enable;

`ifdef RISCV_INT_EDGE_EN
    // Edge mode: a rising edge on a line sets its pending flop; the flop is
    // cleared only when that id is taken (DONE). A new edge in the same
    // cycle as the clear wins, so an edge arriving during DONE is not lost.
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] hist_q, hist_d;
    logic [NUM_IRQ-1:0] pend_clr;

    always_comb begin
        pend_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (state_q == DONE && ID_W'(i) == id_q) begin
                pend_clr[i] = 1'b1;
            end
        end
        pend_d = (pend_q & ~pend_clr) | (bus.irq_i & ~hist_q);
        hist_d = bus.irq_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            hist_q <= '0;
        end else begin
            pend_q <= pend_d;
            hist_q <= hist_d;
        end
    end

    assign src = pend_q;
`else
    assign src = bus.irq_i;
`endif

    assign act     = src & bus.irq_mask_i;
    assign any_act = |act;

    // Ascending scan so the highest active index is the one left in sel.
    // The secure attribute is picked in the same loop to avoid indexing the
    // line vector with the (possibly wider) id.
    always_comb begin
        sel     = '0;
        sel_sec = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (act[i]) begin
                sel     = ID_W'(i);
                sel_sec = bus.irq_sec_i[i];
            end
        end
    end

    // In U mode a secure line is allowed through even with u_IE_i low.
    always_comb begin
        if (PULP_SECURE) begin
            enable = ((bus.u_IE_i | sel_sec) & (bus.current_priv_lvl_i == PRIV_LVL_U)) |
                     (bus.m_IE_i & (bus.current_priv_lvl_i == PRIV_LVL_M));
        end else begin
            enable = bus.m_IE_i;
        end
    end

    // Once PENDING, the request only leaves through ack or kill: line
    // deassertion or a dropped global enable does not cancel it. A higher
    // line may still replace the presented id before acceptance; ack takes
    // precedence over both kill and preemption.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        sec_d   = sec_q;
        case (state_q)
            IDLE: begin
                if (enable && any_act) begin
                    state_d = PENDING;
                    id_d    = sel;
                    sec_d   = sel_sec;
                end
            end
            PENDING: begin
                if (bus.ctrl_ack_i) begin
                    state_d = DONE;
                end else if (bus.ctrl_kill_i) begin
                    state_d = IDLE;
                end else if (enable && any_act && (sel > id_q)) begin
                    id_d  = sel;
                    sec_d = sel_sec;
                end
            end
            DONE: begin
                state_d = IDLE;
                sec_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_d    = (state_d == PENDING);
        ack_d    = (state_d == DONE);
        ack_id_d = (state_d == DONE) ? id_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            id_q     <= '0;
            sec_q    <= 1'b0;
            req_q    <= 1'b0;
            ack_q    <= 1'b0;
            ack_id_q <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            sec_q    <= sec_d;
            req_q    <= req_d;
            ack_q    <= ack_d;
            ack_id_q <= ack_id_d;
        end
    end

    assign bus.irq_req_ctrl_o = req_q;
    assign bus.irq_sec_ctrl_o = sec_q;
    assign bus.irq_id_ctrl_o  = id_q;
    assign bus.irq_ack_o      = ack_q;
    assign bus.irq_ack_id_o   = ack_id_q;

endmodule

// File: tb/tb_riscv_int_controller_mc.sv
// ---------------------------------------------------------------------------
// tb_riscv_int_controller_mc
//
// Two controller instances: u_dut0 (32 lines, 6-bit id, plain enable) and
// u_dut1 (8 lines, 4-bit id, privilege-aware enable). Directed scenarios
// check fixed expected values; a randomized phase compares both instances
// each cycle with a behavioural model built from the interrupt rules.
// ---------------------------------------------------------------------------
module tb_riscv_int_controller_mc;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

`ifdef RISCV_INT_EDGE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    always #5 clk = ~clk;

    riscv_int_controller_mc_if #(.NUM_IRQ(32), .ID_W(6)) bus0 ();
    riscv_int_controller_mc_if #(.NUM_IRQ(8),  .ID_W(4)) bus1 ();

    riscv_int_controller_mc #(.NUM_IRQ(32), .ID_W(6), .PULP_SECURE(1'b0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    riscv_int_controller_mc #(.NUM_IRQ(8), .ID_W(4), .PULP_SECURE(1'b1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Behavioural model state per instance: is a request outstanding, is the
    // taken-pulse showing, which id/secure bit is presented.
    bit          m_req [2];
    bit          m_ack [2];
    int          m_id  [2];
    bit          m_sec [2];
    logic [63:0] m_pend[2];
    logic [63:0] m_hist[2];

    function automatic int top_index(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_req[k]  = 1'b0;
            m_ack[k]  = 1'b0;
            m_id[k]   = 0;
            m_sec[k]  = 1'b0;
            m_pend[k] = '0;
            m_hist[k] = '0;
        end
    endtask

    task automatic model_step(input int k, input int n, input bit ps,
                              input logic [63:0] irq, input logic [63:0] mask,
                              input logic [63:0] sec, input bit mie, input bit uie,
                              input logic [1:0] priv, input bit ack, input bit kill);
        logic [63:0] src;
        int          w;
        bit          en;
`ifdef RISCV_INT_EDGE_EN
        logic [63:0] one;
        one       = 64'd1;
        src       = m_pend[k];
        m_pend[k] = (m_pend[k] & ~(m_ack[k] ? (one << m_id[k]) : 64'd0)) | (irq & ~m_hist[k]);
        m_hist[k] = irq;
`else
        src = irq;
`endif
        w = top_index(src & mask, n);
        if (w < 0)   en = 1'b0;
        else if (ps) en = (priv == 2'b00 && (uie || sec[w])) || (priv == 2'b11 && mie);
        else         en = mie;

        if (m_ack[k]) begin
            m_ack[k] = 1'b0;
            m_sec[k] = 1'b0;
        end else if (m_req[k]) begin
            if (ack) begin
                m_req[k] = 1'b0;
                m_ack[k] = 1'b1;
            end else if (kill) begin
                m_req[k] = 1'b0;
            end else if (en && w > m_id[k]) begin
                m_id[k]  = w;
                m_sec[k] = sec[w];
            end
        end else if (en) begin
            m_req[k] = 1'b1;
            m_id[k]  = w;
            m_sec[k] = sec[w];
        end
    endtask

    // Advance one clock: inputs are captured before the edge, the model is
    // stepped at the edge, outputs are then stable 1 ns later.
    task automatic tick();
        logic [63:0] i0, k0m, s0, i1, k1m, s1;
        bit          e0, u0, a0, q0, e1, u1, a1, q1;
        logic [1:0]  p0, p1;
        i0 = 64'(bus0.irq_i); k0m = 64'(bus0.irq_mask_i); s0 = 64'(bus0.irq_sec_i);
        e0 = bus0.m_IE_i; u0 = bus0.u_IE_i; p0 = bus0.current_priv_lvl_i;
        a0 = bus0.ctrl_ack_i; q0 = bus0.ctrl_kill_i;
        i1 = 64'(bus1.irq_i); k1m = 64'(bus1.irq_mask_i); s1 = 64'(bus1.irq_sec_i);
        e1 = bus1.m_IE_i; u1 = bus1.u_IE_i; p1 = bus1.current_priv_lvl_i;
        a1 = bus1.ctrl_ack_i; q1 = bus1.ctrl_kill_i;
        @(posedge clk);
        if (rst_n) begin
            model_step(0, 32, 1'b0, i0, k0m, s0, e0, u0, p0, a0, q0);
            model_step(1, 8,  1'b1, i1, k1m, s1, e1, u1, p1, a1, q1);
        end
        #1;
    endtask

    task automatic wait_req(input int k, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            tick();
            ok = (k == 0) ? (bus0.irq_req_ctrl_o === 1'b1) : (bus1.irq_req_ctrl_o === 1'b1);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        checks++;
        if ({bus0.irq_req_ctrl_o, bus0.irq_sec_ctrl_o, bus0.irq_id_ctrl_o,
             bus0.irq_ack_o, bus0.irq_ack_id_o} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL reset_dut0: got req=%0b sec=%0b id=%0d ack=%0b ack_id=%0d required all 0",
                     bus0.irq_req_ctrl_o, bus0.irq_sec_ctrl_o, bus0.irq_id_ctrl_o,
                     bus0.irq_ack_o, bus0.irq_ack_id_o);
        end
        checks++;
        if ({bus1.irq_req_ctrl_o, bus1.irq_sec_ctrl_o, bus1.irq_id_ctrl_o,
             bus1.irq_ack_o, bus1.irq_ack_id_o} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_dut1: got req=%0b sec=%0b id=%0d ack=%0b ack_id=%0d required all 0",
                     bus1.irq_req_ctrl_o, bus1.irq_sec_ctrl_o, bus1.irq_id_ctrl_o,
                     bus1.irq_ack_o, bus1.irq_ack_id_o);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus0.irq_i = 32'h1 << 5;
        repeat (LAT - 1) tick();
        checks++;
        if (bus0.irq_req_ctrl_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_early: got req=%0b required 0", bus0.irq_req_ctrl_o);
        end
        tick();
        checks++;
        if ({bus0.irq_req_ctrl_o, bus0.irq_id_ctrl_o} !== {1'b1, 6'd5}) begin
            errors++;
            $display("[TB] FAIL single_req: got req=%0b id=%0d required req=1 id=5",
                     bus0.irq_req_ctrl_o, bus0.irq_id_ctrl_o);
        end
        bus0.ctrl_ack_i = 1'b1;
        tick();
        bus0.ctrl_ack_i = 1'b0;
        bus0.irq_i      = '0;
        checks++;
        if ({bus0.irq_ack_o, bus0.irq_ack_id_o, bus0.irq_req_ctrl_o} !== {1'b1, 6'd5, 1'b0}) begin
            errors++;
            $display("[TB] FAIL single_ack: got ack=%0b ack_id=%0d req=%0b required ack=1 ack_id=5 req=0",
                     bus0.irq_ack_o, bus0.irq_ack_id_o, bus0.irq_req_ctrl_o);
        end
        tick();
        tick();
        checks++;
        if ({bus0.irq_ack_o, bus0.irq_req_ctrl_o} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL single_idle: got ack=%0b req=%0b required 0 0",
                     bus0.irq_ack_o, bus0.irq_req_ctrl_o);
        end
    endtask

    task automatic test_priority();
        bit ok;
        bus0.irq_i = (32'h1 << 3) | (32'h1 << 17);
        wait_req(0, 10, ok);
        checks++;
        if (!ok || bus0.irq_id_ctrl_o !== 6'd17) begin
            errors++;
            $display("[TB] FAIL priority_high: got req=%0b id=%0d required req=1 id=17",
                     bus0.irq_req_ctrl_o, bus0.irq_id_ctrl_o);
        end
        bus0.ctrl_ack_i = 1'b1;
        tick();
        bus0.ctrl_ack_i = 1'b0;
        bus0.irq_i      = 32'h1 << 3;
        wait_req(0, 10, ok);
        checks++;
        if (!ok || bus0.irq_id_ctrl_o !== 6'd3) begin
            errors++;
            $display("[TB] FAIL priority_next: got req=%0b id=%0d required req=1 id=3",
                     bus0.irq_req_ctrl_o, bus0.irq_id_ctrl_o);
        end
        bus0.ctrl_ack_i = 1'b1;
        tick();
        bus0.ctrl_ack_i = 1'b0;
        bus0.irq_i      = '0;
        tick();
        tick();
    endtask

    task automatic test_preempt();
        bit ok;
        bus0.irq_i = 32'h1 << 4;
        wait_req(0, 10, ok);
        checks++;
        if (!ok || bus0.irq_id_ctrl_o !== 6'd4) begin
            errors++;
            $display("[TB] FAIL preempt_first: got req=%0b id=%0d required req=1 id=4",
                     bus0.irq_req_ctrl_o, bus0.irq_id_ctrl_o);
        end
        bus0.irq_i = (32'h1 << 4) | (32'h1 << 9);
        repeat (LAT) tick();
        checks++;
        if ({bus0.irq_req_ctrl_o, bus0.irq_id_ctrl_o} !== {1'b1, 6'd9}) begin
            errors++;
            $display("[TB] FAIL preempt_switch: got req=%0b id=%0d required req=1 id=9",
                     bus0.irq_req_ctrl_o, bus0.irq_id_ctrl_o);
        end
        bus0.ctrl_ack_i = 1'b1;
        tick();
        bus0.ctrl_ack_i = 1'b0;
        bus0.irq_i      = 32'h1 << 4;
        wait_req(0, 10, ok);
        // Higher line rises in the same cycle as the ack: no preemption.
        bus0.irq_i      = (32'h1 << 4) | (32'h1 << 9);
        bus0.ctrl_ack_i = 1'b1;
        tick();
        bus0.ctrl_ack_i = 1'b0;
        bus0.irq_i      = 32'h1 << 9;
        checks++;
        if (!ok || {bus0.irq_ack_o, bus0.irq_ack_id_o} !== {1'b1, 6'd4}) begin
            errors++;
            $display("[TB] FAIL preempt_ack_race: got ack=%0b ack_id=%0d required ack=1 ack_id=4",
                     bus0.irq_ack_o, bus0.irq_ack_id_o);
        end
        wait_req(0, 10, ok);
        checks++;
        if (!ok || bus0.irq_id_ctrl_o !== 6'd9) begin
            errors++;
            $display("[TB] FAIL preempt_after: got req=%0b id=%0d required req=1 id=9",
                     bus0.irq_req_ctrl_o, bus0.irq_id_ctrl_o);
        end
        bus0.ctrl_ack_i = 1'b1;
        tick();
        bus0.ctrl_ack_i = 1'b0;
        bus0.irq_i      = '0;
        tick();
        tick();
    endtask

    task automatic test_ack_kill();
        bit ok;
        bus0.irq_i = 32'h1 << 12;
        wait_req(0, 10, ok);
        bus0.ctrl_ack_i  = 1'b1;
        bus0.ctrl_kill_i = 1'b1;
        tick();
        bus0.ctrl_ack_i  = 1'b0;
        bus0.ctrl_kill_i = 1'b0;
        bus0.irq_i       = '0;
        checks++;
        if (!ok || {bus0.irq_ack_o, bus0.irq_ack_id_o} !== {1'b1, 6'd12}) begin
            errors++;
            $display("[TB] FAIL ack_kill_both: got ack=%0b ack_id=%0d required ack=1 ack_id=12",
                     bus0.irq_ack_o, bus0.irq_ack_id_o);
        end
        tick();
        tick();
        bus0.irq_i = 32'h1 << 12;
        wait_req(0, 10, ok);
        bus0.ctrl_kill_i = 1'b1;
        tick();
        bus0.ctrl_kill_i = 1'b0;
        checks++;
        if (!ok || {bus0.irq_req_ctrl_o, bus0.irq_ack_o, bus0.irq_id_ctrl_o} !== {2'b00, 6'd12}) begin
            errors++;
            $display("[TB] FAIL kill_only: got req=%0b ack=%0b id=%0d required req=0 ack=0 id=12",
                     bus0.irq_req_ctrl_o, bus0.irq_ack_o, bus0.irq_id_ctrl_o);
        end
        tick();
        checks++;
        if ({bus0.irq_req_ctrl_o, bus0.irq_id_ctrl_o} !== {1'b1, 6'd12}) begin
            errors++;
            $display("[TB] FAIL kill_rerequest: got req=%0b id=%0d required req=1 id=12",
                     bus0.irq_req_ctrl_o, bus0.irq_id_ctrl_o);
        end
        bus0.ctrl_ack_i = 1'b1;
        tick();
        bus0.ctrl_ack_i = 1'b0;
        bus0.irq_i      = '0;
        tick();
        tick();
    endtask

    task automatic test_secure();
        bit ok;
        bus1.current_priv_lvl_i = 2'b00;
        bus1.u_IE_i             = 1'b0;
        bus1.m_IE_i             = 1'b0;
        bus1.irq_sec_i          = 8'h04;
        bus1.irq_i              = 8'h04;
        wait_req(1, 10, ok);
        checks++;
        if (!ok || {bus1.irq_sec_ctrl_o, bus1.irq_id_ctrl_o} !== {1'b1, 4'd2}) begin
            errors++;
            $display("[TB] FAIL secure_user: got req=%0b sec=%0b id=%0d required req=1 sec=1 id=2",
                     bus1.irq_req_ctrl_o, bus1.irq_sec_ctrl_o, bus1.irq_id_ctrl_o);
        end
        bus1.ctrl_ack_i = 1'b1;
        tick();
        bus1.ctrl_ack_i = 1'b0;
        bus1.irq_i      = '0;
        checks++;
        if ({bus1.irq_ack_o, bus1.irq_ack_id_o} !== {1'b1, 4'd2}) begin
            errors++;
            $display("[TB] FAIL secure_ack: got ack=%0b ack_id=%0d required ack=1 ack_id=2",
                     bus1.irq_ack_o, bus1.irq_ack_id_o);
        end
        tick();
        tick();
        bus1.irq_sec_i = 8'h00;
        bus1.irq_i     = 8'h04;
        repeat (4) tick();
        checks++;
        if (bus1.irq_req_ctrl_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL secure_blocked: got req=%0b required 0", bus1.irq_req_ctrl_o);
        end
        bus1.current_priv_lvl_i = 2'b11;
        bus1.m_IE_i             = 1'b1;
        wait_req(1, 10, ok);
        checks++;
        if (!ok || {bus1.irq_sec_ctrl_o, bus1.irq_id_ctrl_o} !== {1'b0, 4'd2}) begin
            errors++;
            $display("[TB] FAIL secure_machine: got req=%0b sec=%0b id=%0d required req=1 sec=0 id=2",
                     bus1.irq_req_ctrl_o, bus1.irq_sec_ctrl_o, bus1.irq_id_ctrl_o);
        end
        bus1.ctrl_ack_i = 1'b1;
        tick();
        bus1.ctrl_ack_i = 1'b0;
        bus1.irq_i      = '0;
        tick();
        tick();
    endtask

    task automatic test_edge_reset();
        bit ok;
`ifdef RISCV_INT_EDGE_EN
        bus0.irq_i = 32'h1 << 10;
        wait_req(0, 10, ok);
        bus0.irq_i = (32'h1 << 10) | (32'h1 << 7);
        tick();
        bus0.irq_i      = 32'h1 << 10;
        bus0.ctrl_ack_i = 1'b1;
        tick();
        bus0.ctrl_ack_i = 1'b0;
        bus0.irq_i      = '0;
        wait_req(0, 10, ok);
        checks++;
        if (!ok || bus0.irq_id_ctrl_o !== 6'd7) begin
            errors++;
            $display("[TB] FAIL edge_pulse: got req=%0b id=%0d required req=1 id=7",
                     bus0.irq_req_ctrl_o, bus0.irq_id_ctrl_o);
        end
        bus0.ctrl_ack_i = 1'b1;
        tick();
        bus0.ctrl_ack_i = 1'b0;
        tick();
        tick();
`endif
        bus0.irq_i        = 32'h1 << 20;
        bus0.irq_sec_i    = 32'h1 << 20;
        wait_req(0, 10, ok);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (!ok || {bus0.irq_req_ctrl_o, bus0.irq_sec_ctrl_o, bus0.irq_id_ctrl_o,
                    bus0.irq_ack_o, bus0.irq_ack_id_o} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL reset_pending: got req=%0b sec=%0b id=%0d ack=%0b ack_id=%0d required all 0",
                     bus0.irq_req_ctrl_o, bus0.irq_sec_ctrl_o, bus0.irq_id_ctrl_o,
                     bus0.irq_ack_o, bus0.irq_ack_id_o);
        end
        bus0.irq_i     = '0;
        bus0.irq_sec_i = '0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bus0.irq_req_ctrl_o, bus0.irq_ack_o} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_release: got req=%0b ack=%0b required 0 0",
                     bus0.irq_req_ctrl_o, bus0.irq_ack_o);
        end
    endtask

    task automatic test_random();
        logic [1:0] privs [3];
        privs[0] = 2'b00;
        privs[1] = 2'b01;
        privs[2] = 2'b11;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: bus0.irq_i = '0;
                    1: bus0.irq_i = 32'h1 << $urandom_range(0, 31);
                    2: bus0.irq_i = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
                    default: bus0.irq_i = $urandom & $urandom & $urandom;
                endcase
                bus1.irq_i = 8'($urandom & $urandom);
            end
            bus0.irq_mask_i         = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
            bus0.irq_sec_i          = $urandom;
            bus0.m_IE_i             = ($urandom_range(0, 7) != 0);
            bus0.u_IE_i             = 1'($urandom);
            bus0.current_priv_lvl_i = privs[$urandom_range(0, 2)];
            bus0.ctrl_ack_i         = ($urandom_range(0, 3) == 0);
            bus0.ctrl_kill_i        = ($urandom_range(0, 9) == 0);
            bus1.irq_mask_i         = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            bus1.irq_sec_i          = 8'($urandom);
            bus1.m_IE_i             = 1'($urandom);
            bus1.u_IE_i             = 1'($urandom);
            bus1.current_priv_lvl_i = privs[$urandom_range(0, 2)];
            bus1.ctrl_ack_i         = ($urandom_range(0, 3) == 0);
            bus1.ctrl_kill_i        = ($urandom_range(0, 9) == 0);
            tick();
            checks++;
            if ({bus0.irq_req_ctrl_o, bus0.irq_sec_ctrl_o, bus0.irq_id_ctrl_o,
                 bus0.irq_ack_o, bus0.irq_ack_id_o} !==
                {m_req[0], m_sec[0], 6'(m_id[0]), m_ack[0], (m_ack[0] ? 6'(m_id[0]) : 6'd0)}) begin
                errors++;
                $display("[TB] FAIL random_dut0 cycle %0d: got req=%0b sec=%0b id=%0d ack=%0b ack_id=%0d required req=%0b sec=%0b id=%0d ack=%0b",
                         c, bus0.irq_req_ctrl_o, bus0.irq_sec_ctrl_o, bus0.irq_id_ctrl_o,
                         bus0.irq_ack_o, bus0.irq_ack_id_o, m_req[0], m_sec[0], m_id[0], m_ack[0]);
            end
            checks++;
            if ({bus1.irq_req_ctrl_o, bus1.irq_sec_ctrl_o, bus1.irq_id_ctrl_o,
                 bus1.irq_ack_o, bus1.irq_ack_id_o} !==
                {m_req[1], m_sec[1], 4'(m_id[1]), m_ack[1], (m_ack[1] ? 4'(m_id[1]) : 4'd0)}) begin
                errors++;
                $display("[TB] FAIL random_dut1 cycle %0d: got req=%0b sec=%0b id=%0d ack=%0b ack_id=%0d required req=%0b sec=%0b id=%0d ack=%0b",
                         c, bus1.irq_req_ctrl_o, bus1.irq_sec_ctrl_o, bus1.irq_id_ctrl_o,
                         bus1.irq_ack_o, bus1.irq_ack_id_o, m_req[1], m_sec[1], m_id[1], m_ack[1]);
            end
        end
    endtask

    initial begin
        bus0.irq_i              = '0;
        bus0.irq_mask_i         = 32'hFFFF_FFFF;
        bus0.irq_sec_i          = '0;
        bus0.m_IE_i             = 1'b1;
        bus0.u_IE_i             = 1'b0;
        bus0.current_priv_lvl_i = 2'b11;
        bus0.ctrl_ack_i         = 1'b0;
        bus0.ctrl_kill_i        = 1'b0;
        bus1.irq_i              = '0;
        bus1.irq_mask_i         = 8'hFF;
        bus1.irq_sec_i          = '0;
        bus1.m_IE_i             = 1'b0;
        bus1.u_IE_i             = 1'b0;
        bus1.current_priv_lvl_i = 2'b11;
        bus1.ctrl_ack_i         = 1'b0;
        bus1.ctrl_kill_i        = 1'b0;
        #1;
        $display("[TB] start");
        test_reset();
        test_single();
        test_priority();
        test_preempt();
        test_ack_kill();
        test_secure();
        test_edge_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] time limit");
    end

endmodule
